instr_fetch_unit: RTL

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit_pkg.sv | 16 +
 rtl/instr_fetch_unit_if.sv | 37 +++
 rtl/instr_fetch_unit_pc_next_sel.sv | 34 +++
 rtl/instr_fetch_unit.sv | 98 +++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit.
//   fetch_state_e    : fetch controller states (BOOT, FETCH, HOLD)
//   DEFAULT_RESET_PC : default first fetch address after reset
//   INSTR_W          : instruction word / address width
package mips_pkg;

  localparam int          INSTR_W          = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bus bundle between the fetch unit, the instruction memory and the core.
//   master : fetch unit side (drives imem request and the presented instruction)
//   slave  : environment side (memory response, stall and redirect controls)
interface instr_fetch_unit_if #(parameter int CNT_W = 16);
  import mips_pkg::*;

  // core -> fetch
  logic               stall;
  logic               jump;
  logic [INSTR_W-1:0] jump_target;
  logic               branch_taken;
  logic [INSTR_W-1:0] branch_target;
  // memory -> fetch
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  // fetch -> memory
  logic               imem_req;
  logic [INSTR_W-1:0] imem_addr;
  // fetch -> core
  logic [INSTR_W-1:0] instruction;
  logic [INSTR_W-1:0] pc;
  logic [INSTR_W-1:0] pc4;
  logic               instr_valid;
  logic               misalign_err;
  logic [CNT_W-1:0]   fetch_count;

  modport master (
    input  stall, jump, jump_target, branch_taken, branch_target, imem_ack, imem_rdata,
    output imem_req, imem_addr, instruction, pc, pc4, instr_valid, misalign_err, fetch_count
  );

  modport slave (
    output stall, jump, jump_target, branch_taken, branch_target, imem_ack, imem_rdata,
    input  imem_req, imem_addr, instruction, pc, pc4, instr_valid, misalign_err, fetch_count
  );

endinterface

// File: rtl/instr_fetch_unit_pc_next_sel.sv
// Combinational next-fetch-PC selection for an accepted instruction.
//   jump_i/jump_target_i     : jump redirect (highest priority)
//   branch_i/branch_target_i : taken-branch redirect
//   pc4_i                    : sequential fall-through address
//   next_pc_o                : selected address, low two bits cleared
//   misalign_o               : selected redirect target had nonzero low bits
module pc_next_sel
  import mips_pkg::*;
(
  input  logic               jump_i,
  input  logic [INSTR_W-1:0] jump_target_i,
  input  logic               branch_i,
  input  logic [INSTR_W-1:0] branch_target_i,
  input  logic [INSTR_W-1:0] pc4_i,
  output logic [INSTR_W-1:0] next_pc_o,
  output logic               misalign_o
);

  logic [INSTR_W-1:0] raw;

  always_comb begin
    raw        = pc4_i;
    misalign_o = 1'b0;
    if (jump_i) begin
      raw        = jump_target_i;
      misalign_o = |jump_target_i[1:0];
    end else if (branch_i) begin
      raw        = branch_target_i;
      misalign_o = |branch_target_i[1:0];
    end
    next_pc_o = {raw[INSTR_W-1:2], 2'b00};
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: one outstanding request to instruction memory,
// holds the returned word until the core accepts it, then computes the
// next fetch address (jump > branch > pc+4).
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : instr_fetch_unit_if master (memory handshake, core handshake,
//                redirect inputs, status outputs)
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          CNT_W    = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  instr_fetch_unit_if.master     bus
);

  fetch_state_e       state_q, state_d;
  logic [INSTR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [INSTR_W-1:0] pc_q, pc_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [INSTR_W-1:0] pc4;
  logic [INSTR_W-1:0] nxt_pc;
  logic               nxt_misalign;

  // wraps naturally at 2^32
  assign pc4 = pc_q + 32'd4;

  pc_next_sel u_sel (
    .jump_i          (bus.jump),
    .jump_target_i   (bus.jump_target),
    .branch_i        (bus.branch_taken),
    .branch_target_i (bus.branch_target),
    .pc4_i           (pc4),
    .next_pc_o       (nxt_pc),
    .misalign_o      (nxt_misalign)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      fetch_pc_q <= RESET_PC;
      instr_q    <= '0;
      pc_q       <= RESET_PC;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  // Redirect inputs and stall only matter in HOLD; ack only in FETCH.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    instr_d    = instr_q;
    pc_d       = pc_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      BOOT: state_d = FETCH;
      FETCH: begin
        if (bus.imem_ack) begin
          instr_d = bus.imem_rdata;
          pc_d    = fetch_pc_q;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (!bus.stall) begin
          fetch_pc_d = nxt_pc;
          err_d      = err_q | nxt_misalign;
          cnt_d      = cnt_q + CNT_W'(1);
          state_d    = FETCH;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  assign bus.imem_req     = (state_q == FETCH);
  assign bus.imem_addr    = fetch_pc_q;
  assign bus.instruction  = instr_q;
  assign bus.pc           = pc_q;
  assign bus.pc4          = pc4;
  assign bus.instr_valid  = (state_q == HOLD);
  assign bus.misalign_err = err_q;
  assign bus.fetch_count  = cnt_q;

endmodule
